// File: rtl/soc_system_pio_in_db.sv
`default_nettype none
// ============================================================================
//  Module   : soc_system_pio_in_db
//  Purpose  : Avalon-MM input PIO for the HPS lightweight bridge. Samples an
//             asynchronous input bus through a synchroniser chain and an
//             optional per-bit debouncer, captures enabled rising/falling
//             edges (write-1-to-clear) and raises a masked level interrupt.
//  Config   : define PIO_DEBOUNCE_EN to build the per-bit debouncer; without
//             it the synchroniser output feeds edge detection directly.
//  Revision : 1.0 - initial release
// ============================================================================
module soc_system_pio_in_db #(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Reject configurations outside the supported range at elaboration time.
  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_bad_params
    $error("soc_system_pio_in_db: parameter out of range");
  end

  // Upper write-data bits are not mapped to any register.
  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  // Synchroniser: stage 0 in the low WIDTH bits, last stage in the top bits.
  logic [SYNC_STAGES*WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]             sync_raw;
  logic [WIDTH-1:0]             db_data;

  assign sync_d   = {sync_q[(SYNC_STAGES-1)*WIDTH-1:0], in_port};
  assign sync_raw = sync_q[SYNC_STAGES*WIDTH-1 -: WIDTH];

  // Shift the asynchronous inputs through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= sync_d;
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [WIDTH-1:0]         stable_q, stable_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  // A bit only flips after DB_CYCLES consecutive samples disagree with it;
  // any agreeing sample restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_raw[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
        stable_d[i] = sync_raw[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Debouncer state; asynchronous reset aborts any count in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign db_data = stable_q;
`else
  assign db_data = sync_raw;
`endif

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise, fall;
  logic [WIDTH-1:0] rd_sel;

  // Register writes, edge capture with set-over-clear priority, read mux.
  always_comb begin
    wr    = chipselect & ~write_n;
    wdata = writedata[WIDTH-1:0];
    rise  = db_data & ~prev_q & rise_en_q;
    fall  = ~db_data & prev_q & fall_en_q;

    prev_d     = db_data;
    rise_en_d  = (wr && address == 3'd1) ? wdata : rise_en_q;
    irq_mask_d = (wr && address == 3'd2) ? wdata : irq_mask_q;
    fall_en_d  = (wr && address == 3'd4) ? wdata : fall_en_q;

    edge_capture_d = edge_capture_q;
    if (wr && address == 3'd3) begin
      edge_capture_d = edge_capture_d & ~wdata;
    end
    // New events are ORed in after the clear so a coincident event survives.
    edge_capture_d = edge_capture_d | rise | fall;

    rd_sel = '0;
    case (address)
      3'd0:    rd_sel = db_data;
      3'd1:    rd_sel = rise_en_q;
      3'd2:    rd_sel = irq_mask_q;
      3'd3:    rd_sel = edge_capture_q;
      3'd4:    rd_sel = fall_en_q;
      3'd5:    rd_sel = sync_raw;
      default: rd_sel = '0;
    endcase
    readdata_d = 32'(rd_sel);
  end

  // Control/status registers and the registered read port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q         <= '0;
      rise_en_q      <= '0;
      fall_en_q      <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      readdata_q     <= '0;
    end else begin
      prev_q         <= prev_d;
      rise_en_q      <= rise_en_d;
      fall_en_q      <= fall_en_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_capture_q & irq_mask_q);

endmodule
`default_nettype wire

// File: doc/soc_system_pio_in_db.md
# soc_system_pio_in_db

Parametrised Avalon-MM input PIO for the HPS lightweight bridge. It samples a WIDTH-bit asynchronous input bus through a synchroniser chain and an optional per-bit debouncer. Software can independently enable rising-edge and falling-edge capture per bit, clear captured edges bit by bit (write-1-to-clear), and receive a level interrupt. It replaces the fixed 10-bit any-edge switch port.

## Interface
- WIDTH, 10: input bus width, 1..32
- SYNC_STAGES, 2: synchroniser flops per bit, ≥2
- DB_CYCLES, 4: stable cycles required before a debounced bit changes, ≥1; counter width CW = $clog2(DB_CYCLES+1)

- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits [WIDTH-1:0] used
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  registered read data, zero-extended
- irq  out  1  level interrupt

## Operation
- Register map (addr: name, access):
  - 0: db_data, RO
  - 1: rise_en, RW
  - 2: irq_mask, RW
  - 3: edge_capture, W1C
  - 4: fall_en, RW
  - 5: sync_raw, RO
  - 6–7: read 0, writes ignored
- Write strobe = chipselect && !write_n. Writes to RO addresses are ignored.
- sync_raw is the last stage of a SYNC_STAGES-deep flop chain per bit.
- Debouncer, per bit, with registers stable[i] and cnt[i]:
  - If sync_raw[i] == stable[i]: cnt ← 0.
  - Else if cnt == DB_CYCLES-1: stable ← sync_raw, cnt ← 0.
  - Else: cnt ← cnt+1.
  - Any return to the stable value restarts the count. A glitch shorter than DB_CYCLES cycles never reaches db_data.
- db_data = stable. prev ← db_data every cycle.
- Edge detection:
  - rise = db_data & ~prev & rise_en
  - fall = ~db_data & prev & fall_en
- edge_capture[i] is set when (rise|fall)[i]. A write to addr 3 clears every bit where writedata[i] = 1.
- Simultaneous set and clear on the same bit: set wins, so no event is lost.
- irq = |(edge_capture & irq_mask), driven combinationally from registers.
- Disabling rise_en/fall_en/irq_mask does not clear edge_capture.

## Timing
- Reset: all sync flops, stable, cnt, prev, rise_en, fall_en, irq_mask, edge_capture and readdata go to 0; irq = 0. Reset is asynchronous, so assertion mid-debounce aborts all counts immediately.
- readdata is registered every cycle from the address mux regardless of chipselect. Read latency is 1 cycle (readLatency=1).
- Let in_port[i] change before edge 0 and stay steady:
  - sync_raw changes at edge SYNC_STAGES.
  - db_data changes at edge SYNC_STAGES+DB_CYCLES.
  - edge_capture and irq change at edge SYNC_STAGES+DB_CYCLES+1.
  - Data visible on readdata one edge after each of those.
- Register writes take effect at the write edge. An irq_mask write changes irq in the same cycle after the edge.
- After reset, inputs held high produce a rising edge once debounced (stable resets to 0). Software clears edge_capture after enabling.

## Configuration
- PIO_DEBOUNCE_EN defined:
  - debouncer as above
- PIO_DEBOUNCE_EN undefined:
  - stable and cnt are removed; db_data = sync_raw
  - DB_CYCLES is ignored
  - edge_capture sets at edge SYNC_STAGES+1 after an input change
  - register map unchanged; address 0 and address 5 read identical values

## Test plan
Bench configuration: WIDTH=10, SYNC_STAGES=2, DB_CYCLES=4, macro defined.
- Reset check: assert reset_n=0 with in_port=0x3FF → all readable registers read 0 and irq=0; after release, address 0 reads 0x000 until cycle 6.
- Rising edge with interrupt: write rise_en=0x001, irq_mask=0x001, edge_capture=0x3FF; raise in_port[0] → irq rises exactly 7 edges later; address 3 reads 0x001; writing 0x001 to address 3 drops irq the next cycle.
- Glitch rejection: pulse in_port[1] high for 3 cycles with rise_en=0x3FF → address 0 bit1 stays 0, address 3 reads 0x000, irq stays 0.
- Falling edge only: fall_en=0x200, rise_en=0; raise in_port[9] then drop it → no capture on the rise; address 3 reads 0x200 after the fall.
- Same-cycle set and clear: write 0x004 to address 3 on the same edge that bit2's capture fires → edge_capture[2] stays 1. Write 0x001 while bits 0 and 2 are set → only bit0 clears.
- Reset mid-operation: assert reset_n during debounce (cnt=2) → db_data, edge_capture and readdata are 0 immediately; after release, the held input needs the full 2+4 cycles again.
